// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO for in-order bookkeeping of outstanding
// transactions (push on request handshake, pop on response handshake).
// Provides full / empty / fill-threshold flags and a synchronous flush.
//
// Optional build macro: FIFO_FALL_THROUGH_EN
//   undefined (default): all outputs derive from registered state only.
//   defined: an empty FIFO presents data_i on data_o in the push cycle;
//            a same-cycle pop consumes it without it ever being stored.
module fifo_sync #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned THRESHOLD  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  testmode_i,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  threshold_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    // Pointers need at least one bit even for a single-entry FIFO.
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(THRESHOLD);

    // Reject illegal configurations at elaboration time.
    if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync: DEPTH must be a power of two >= 1");
    end
    if (THRESHOLD < 1 || THRESHOLD > DEPTH) begin : g_bad_thr
        $error("fifo_sync: THRESHOLD must lie in 1..DEPTH");
    end

    // testmode_i has no functional effect; tie it off explicitly.
    logic unused_testmode;
    assign unused_testmode = testmode_i;

    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

    logic is_empty;
    logic is_full;
    logic bypass;
    logic push_acc;
    logic pop_acc;

    // Pointer advance with explicit wrap; a plain increment would not wrap
    // correctly when DEPTH == 1 (one-bit pointer, single slot).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

`ifdef FIFO_FALL_THROUGH_EN
    // Empty with push and pop together: the entry flows straight through.
    assign bypass = is_empty & push_i & pop_i;
`else
    assign bypass = 1'b0;
`endif

    // A push while full and a pop while empty are silently dropped.
    assign push_acc = push_i & ~is_full & ~bypass;
    assign pop_acc  = pop_i & ~is_empty;

    // Next-state for pointers and occupancy; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_acc)  rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage: cleared by reset so data_o reads zero afterwards; flush only
    // drops occupancy and leaves the slot contents in place.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else if (push_acc && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign full_o      = is_full;
    assign threshold_o = (count_q >= CNT_THR);

`ifdef FIFO_FALL_THROUGH_EN
    // An incoming push makes an empty FIFO look non-empty immediately.
    assign empty_o = is_empty & ~push_i;
    assign data_o  = (is_empty && push_i) ? data_i : mem_q[rd_ptr_q];
`else
    // Head slot read; stale when empty.
    assign empty_o = is_empty;
    assign data_o  = mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync (DEPTH=4, THRESHOLD=2, 8-bit data). A queue model
// tracks contents from the push/pop/flush rules and is compared against
// the DUT every falling edge; directed literal checks pin the model.
module tb_fifo_sync;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int THR   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          testmode = 1'b0;
    logic          flush = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] din = '0;
    logic          full, empty, thr;
    logic [DW-1:0] dout;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];

    always #5 clk = ~clk;

    fifo_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .THRESHOLD(THR)) dut (
        .clk_i(clk), .rst_i(rst), .testmode_i(testmode), .flush_i(flush),
        .full_o(full), .empty_o(empty), .threshold_o(thr),
        .data_i(din), .push_i(push), .data_o(dout), .pop_i(pop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue semantics straight from the push/pop rules.
    int mn;
    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            model_q.delete();
        end else begin
            mn = model_q.size();
`ifdef FIFO_FALL_THROUGH_EN
            if (!(mn == 0 && push && pop)) begin
`else
            begin
`endif
                if (pop && mn > 0) void'(model_q.pop_front());
                if (push && mn < DEPTH) model_q.push_back(din);
            end
        end
    end

    // Per-cycle compare against the model.
    int cn;
    always @(negedge clk) begin
        if (!rst) begin
            cn = model_q.size();
            chk("m_full", full, cn == DEPTH);
            chk("m_thr", thr, cn >= THR);
`ifdef FIFO_FALL_THROUGH_EN
            if (cn == 0 && push) begin
                chk("m_empty_ft", empty, 0);
                chk("m_data_ft", dout, din);
            end else begin
`else
            begin
`endif
                chk("m_empty", empty, cn == 0);
                if (cn > 0) chk("m_data", dout, model_q[0]);
            end
        end
    end

    task automatic drive(input logic p, input logic q, input logic [DW-1:0] d, input logic f);
        push = p; pop = q; din = d; flush = f;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    task automatic cyc(input logic p, input logic q, input logic [DW-1:0] d, input logic f);
        drive(p, q, d, f);
        tick();
    endtask

    // Directed sampling point: just after the falling edge.
    task automatic peek();
        @(negedge clk); #1;
    endtask

    logic [DW-1:0] e;

    initial begin
        // Reset asserted: flags and data at reset values.
        #12;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_thr", thr, 0);
        chk("rst_data", dout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        peek();
        chk("idle_empty", empty, 1);
        chk("idle_data", dout, 0);

        // Fill to full, threshold at 2, full at 4.
        cyc(1, 0, 8'hA1, 0); peek();
        chk("p1_empty", empty, 0); chk("p1_thr", thr, 0); chk("p1_data", dout, 8'hA1);
        cyc(1, 0, 8'hA2, 0); peek();
        chk("p2_thr", thr, 1); chk("p2_full", full, 0);
        cyc(1, 0, 8'hA3, 0);
        cyc(1, 0, 8'hA4, 0); peek();
        chk("p4_full", full, 1);
        cyc(1, 0, 8'hFF, 0); peek();
        chk("p5_full", full, 1); chk("p5_head", dout, 8'hA1);
        for (int i = 0; i < 4; i++) begin
            e = 8'hA1 + 8'(i);
            chk("pop_order", dout, e);
            cyc(0, 1, 8'h00, 0); peek();
        end
        chk("drain_empty", empty, 1);

        // Full with push+pop: pop accepted, push dropped.
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'hB1 + 8'(i), 0);
        peek(); chk("b_full", full, 1);
        cyc(1, 1, 8'hBB, 0); peek();
        chk("bb_full", full, 0); chk("bb_thr", thr, 1); chk("bb_head", dout, 8'hB2);
        for (int i = 0; i < 3; i++) begin
            e = 8'hB2 + 8'(i);
            chk("bb_order", dout, e);
            cyc(0, 1, 8'h00, 0); peek();
        end
        chk("bb_empty", empty, 1);

        // Wrap: 10 push+pop pairs at count 2.
        cyc(1, 0, 8'hC0, 0);
        cyc(1, 0, 8'hC1, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 8'hD0 + 8'(i), 0); peek();
            e = (i == 0) ? 8'hC1 : 8'hD0 + 8'(i - 1);
            chk("wrap_head", dout, e);
            chk("wrap_thr", thr, 1);
            chk("wrap_full", full, 0);
        end
        chk("wrap_d8", dout, 8'hD8);
        cyc(0, 1, 8'h00, 0); peek();
        chk("wrap_d9", dout, 8'hD9);
        cyc(0, 1, 8'h00, 0); peek();
        chk("wrap_empty", empty, 1);

        // Flush with concurrent push.
        cyc(1, 0, 8'hE1, 0);
        cyc(1, 0, 8'hE2, 0);
        cyc(1, 0, 8'hE3, 0); peek();
        chk("e_thr", thr, 1);
        cyc(1, 0, 8'h66, 1); peek();
        chk("fl_empty", empty, 1); chk("fl_thr", thr, 0);
        cyc(1, 0, 8'h55, 0); peek();
        chk("fl_data", dout, 8'h55); chk("fl_nempty", empty, 0);
        cyc(0, 1, 8'h00, 0); peek();
        chk("fl_drain", empty, 1);

        // Empty FIFO, push 0x77 with pop in the same cycle.
        tick();
        drive(1, 1, 8'h77, 0); peek();
`ifdef FIFO_FALL_THROUGH_EN
        chk("ft_data", dout, 8'h77);
        chk("ft_empty", empty, 0);
        tick(); peek();
        chk("ft_after_empty", empty, 1);
`else
        chk("nft_empty", empty, 1);
        tick(); peek();
        chk("nft_data", dout, 8'h77);
        chk("nft_empty_after", empty, 0);
        chk("nft_thr", thr, 0);
        cyc(0, 1, 8'h00, 0); peek();
        chk("nft_drain", empty, 1);
`endif

        // Asynchronous reset mid-operation.
        cyc(1, 0, 8'hF1, 0);
        cyc(1, 0, 8'hF2, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_thr", thr, 0);
        chk("arst_data", dout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1, 0, 8'h12, 0); peek();
        chk("arst_push", dout, 8'h12);
        chk("arst_nempty", empty, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule
